// File: rtl/mono_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mono_tx_pkg
// Description : Shared constants, hit-word field layout and FSM state type
//               for the monolithic-sensor serial hit transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package mono_tx_pkg;

    localparam int WORD_W  = 26;

    // Hit word layout: col[25:20], row[19:12], TE[11:6], LE[5:0]
    localparam int COL_LSB = 20;
    localparam int COL_W   = 6;
    localparam int ROW_LSB = 12;
    localparam int ROW_W   = 8;
    localparam int TE_LSB  = 6;
    localparam int TE_W    = 6;
    localparam int LE_LSB  = 0;
    localparam int LE_W    = 6;

    localparam int                   BIT_CNT_W    = $clog2(WORD_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(WORD_W - 1);
    localparam logic [WORD_W-1:0]    TEST_PATTERN = 26'h2AAAAAA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mono_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mono_tx_fifo
// Description : Synchronous first-word-fall-through hit FIFO with occupancy
//               count. A write while full is accepted only if a read frees
//               the slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mono_tx_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 26,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd && !empty;
    assign wr_ok   = wr && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mono_data_tx.sv
`default_nettype none
// ============================================================================
// Module      : mono_data_tx
// Description : Hit FIFO plus freeze/read handshake and 26-bit MSB-first
//               serialiser. Optional macro MONO_TX_TEST_PATTERN_EN adds
//               EN_TEST_PATTERN to shift a fixed pattern instead of FIFO data.
// Revision    : 1.0 - initial release
// ============================================================================
module mono_data_tx
    import mono_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HIT_WR,
    input  logic [WORD_W-1:0] HIT_DATA,
`ifdef MONO_TX_TEST_PATTERN_EN
    input  logic              EN_TEST_PATTERN,
`endif
    output logic              HIT_FULL,
    input  logic              READ,
    input  logic              FREEZE,
    output logic              TOKEN,
    output logic              DATA,
    output logic              BUSY,
    output logic [7:0]        LOST_CNT
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t                state;
    state_t                state_next;
    logic                  read_q;
    logic                  freeze_q;
    logic                  read_rise;
    logic                  freeze_rise;
    logic                  freeze_fall;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [WORD_W-1:0]     fifo_rd_data;
    logic [WORD_W-1:0]     load_word;
    logic [CNT_W-1:0]      snap_cnt;
    logic [CNT_W-1:0]      snap_next;
    logic [WORD_W-1:0]     shreg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  token;
    logic [7:0]            lost_cnt;

    mono_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr      (HIT_WR),
        .wr_data (HIT_DATA),
        .rd      (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign read_rise   = READ && !read_q;
    assign freeze_rise = FREEZE && !freeze_q;
    assign freeze_fall = !FREEZE && freeze_q;

`ifdef MONO_TX_TEST_PATTERN_EN
    assign load_word = EN_TEST_PATTERN ? TEST_PATTERN : fifo_rd_data;
`else
    assign load_word = fifo_rd_data;
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (read_rise && FREEZE && (snap_cnt != '0)) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pop        = !fifo_empty;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A freeze edge overrides the per-word decrement
    always_comb begin
        snap_next = snap_cnt;
        if (freeze_rise) begin
            snap_next = fifo_count;
        end else if (freeze_fall) begin
            snap_next = '0;
        end else if ((state == ST_LOAD) && (snap_cnt != '0)) begin
            snap_next = snap_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            read_q   <= 1'b0;
            freeze_q <= 1'b0;
            snap_cnt <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            token    <= 1'b0;
            lost_cnt <= '0;
        end else begin
            state    <= state_next;
            read_q   <= READ;
            freeze_q <= FREEZE;
            snap_cnt <= snap_next;
            if (state == ST_LOAD) begin
                shreg   <= load_word;
                bit_cnt <= '0;
            end else if (state == ST_SHIFT) begin
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
            // Hits written during freeze stay invisible until FREEZE drops
            if (FREEZE) begin
                token <= (snap_next != '0) || (state_next != ST_IDLE);
            end else begin
                token <= (fifo_count != '0);
            end
            if (HIT_WR && fifo_full && !pop && (lost_cnt != 8'hFF)) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
        end
    end

    assign DATA     = (state == ST_SHIFT) && shreg[WORD_W-1];
    assign BUSY     = (state != ST_IDLE);
    assign TOKEN    = token;
    assign LOST_CNT = lost_cnt;
    assign HIT_FULL = fifo_full && !RST;

endmodule
`default_nettype wire

// File: tb/tb_mono_data_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mono_data_tx
// Description : Self-checking bench: per-cycle behavioural model comparison
//               plus directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mono_data_tx;
    import mono_tx_pkg::*;

    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hit_wr = 1'b0;
    logic [WORD_W-1:0] hit_data = '0;
    logic              read = 1'b0;
    logic              freeze = 1'b0;
    logic              en_tp = 1'b0;
    logic              hit_full;
    logic              token;
    logic              dout;
    logic              busy;
    logic [7:0]        lost_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mono_data_tx #(.DEPTH(DEPTH)) dut (
        .CLK             (clk),
        .RST             (rst),
        .HIT_WR          (hit_wr),
        .HIT_DATA        (hit_data),
`ifdef MONO_TX_TEST_PATTERN_EN
        .EN_TEST_PATTERN (en_tp),
`endif
        .HIT_FULL        (hit_full),
        .READ            (read),
        .FREEZE          (freeze),
        .TOKEN           (token),
        .DATA            (dout),
        .BUSY            (busy),
        .LOST_CNT        (lost_cnt)
    );

    // Behavioural model: queue FIFO, readout age counts edges since accept
    // (0 = loading, 1..26 = bit 26-age on the line, -1 = idle).
    logic [WORD_W-1:0] m_q[$];
    int                m_snap = 0;
    int                m_lost = 0;
    int                m_age  = -1;
    bit                m_token = 1'b0;
    bit                m_read_q = 1'b0;
    bit                m_freeze_q = 1'b0;
    logic [WORD_W-1:0] m_word = '0;

    always @(posedge clk) begin : model
        int cnt;
        int old_age;
        bit pop;
        bit acc;
        if (rst) begin
            m_q.delete();
            m_snap = 0; m_lost = 0; m_age = -1; m_token = 1'b0;
            m_read_q = 1'b0; m_freeze_q = 1'b0;
        end else begin
            cnt = m_q.size();
            old_age = m_age;
            pop = 1'b0;
            if (old_age == 0) begin
                pop    = (cnt > 0);
                m_word = en_tp ? TEST_PATTERN : ((cnt > 0) ? m_q[0] : '0);
                m_age  = 1;
            end else if (old_age > 0) begin
                m_age = (old_age == 26) ? -1 : old_age + 1;
            end else if (read && !m_read_q && freeze && m_snap > 0) begin
                m_age = 0;
            end
            if (freeze && !m_freeze_q)      m_snap = cnt;
            else if (!freeze && m_freeze_q) m_snap = 0;
            else if (old_age == 0 && m_snap > 0) m_snap = m_snap - 1;
            acc = hit_wr && (cnt < DEPTH || pop);
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(hit_data);
            else if (hit_wr && m_lost < 255) m_lost = m_lost + 1;
            m_token = freeze ? (m_snap != 0 || m_age != -1) : (cnt != 0);
            m_read_q = read;
            m_freeze_q = freeze;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic exp_data;
        if (chk_en) begin
            exp_data = (m_age >= 1 && m_age <= 26) ? m_word[26 - m_age] : 1'b0;
            check("model DATA", 32'(dout), 32'(exp_data));
            check("model BUSY", 32'(busy), 32'(m_age != -1));
            check("model TOKEN", 32'(token), 32'(m_token));
            check("model LOST_CNT", 32'(lost_cnt), 32'(m_lost));
            check("model HIT_FULL", 32'(hit_full), 32'(m_q.size() == DEPTH && !rst));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; hit_wr = 1'b0; read = 1'b0; freeze = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write_hit(input logic [WORD_W-1:0] w);
        hit_wr = 1'b1; hit_data = w;
        tick();
        hit_wr = 1'b0;
    endtask

    // Pulses READ, then samples 26 bits; optional second READ edge mid-shift
    task automatic read_word(input int glitch_at, output logic [WORD_W-1:0] w);
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        for (int i = 0; i < WORD_W; i++) begin
            w[WORD_W-1-i] = dout;
            read = (i == glitch_at);
            tick();
        end
        read = 1'b0;
    endtask

    initial begin : stim
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] saved[3];

        do_reset();
        chk_en = 1'b1;
        check("reset TOKEN", 32'(token), 32'd0);
        check("reset DATA", 32'(dout), 32'd0);
        check("reset BUSY", 32'(busy), 32'd0);
        check("reset LOST_CNT", 32'(lost_cnt), 32'd0);

        // Single word readout
        write_hit(26'h3C0F0A5);
        freeze = 1'b1;
        tick();
        check("freeze TOKEN", 32'(token), 32'd1);
        read_word(-1, w);
        check("serial word", 32'(w), 32'h3C0F0A5);
        check("token after word", 32'(token), 32'd0);
        check("idle DATA", 32'(dout), 32'd0);

        // Snapshot excludes hits written during freeze
        do_reset();
        for (int k = 0; k < 3; k++) begin
            saved[k] = 26'($urandom);
            write_hit(saved[k]);
        end
        freeze = 1'b1;
        tick();
        write_hit(26'h1111111);
        write_hit(26'h2222222);
        for (int k = 0; k < 3; k++) begin
            read_word(-1, w);
            check("snapshot word", 32'(w), 32'(saved[k]));
        end
        check("token after snapshot", 32'(token), 32'd0);
        freeze = 1'b0;
        tick();
        check("token after unfreeze", 32'(token), 32'd1);

        // Overflow and saturation
        do_reset();
        for (int k = 0; k < 20; k++) write_hit(26'($urandom));
        check("full flag", 32'(hit_full), 32'd1);
        check("lost 4", 32'(lost_cnt), 32'd4);
        for (int k = 0; k < 300; k++) write_hit(26'($urandom));
        check("lost saturate", 32'(lost_cnt), 32'd255);
        rst = 1'b1;
        #1;
        check("full in reset", 32'(hit_full), 32'd0);

        // Ignored READ edges
        do_reset();
        write_hit(26'h0ABCDEF);
        write_hit(26'h1234567);
        freeze = 1'b1;
        tick();
        read_word(5, w);
        check("word with mid-shift read", 32'(w), 32'h0ABCDEF);
        check("token second pending", 32'(token), 32'd1);
        read_word(-1, w);
        check("second word", 32'(w), 32'h1234567);
        freeze = 1'b0;
        write_hit(26'h0000001);
        read = 1'b1;
        tick();
        read = 1'b0;
        check("read unfrozen busy", 32'(busy), 32'd0);
        tick();
        check("read unfrozen token", 32'(token), 32'd1);

        // Reset in the middle of a shift
        do_reset();
        write_hit(26'h2F0F0F0);
        freeze = 1'b1;
        tick();
        read = 1'b1;
        tick();
        read = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        check("mid-shift busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rst DATA", 32'(dout), 32'd0);
        check("rst TOKEN", 32'(token), 32'd0);
        check("rst BUSY", 32'(busy), 32'd0);
        check("rst LOST_CNT", 32'(lost_cnt), 32'd0);
        rst = 1'b0;
        freeze = 1'b0;
        tick(); tick();
        check("fifo empty after rst", 32'(token), 32'd0);

`ifdef MONO_TX_TEST_PATTERN_EN
        do_reset();
        en_tp = 1'b1;
        write_hit(26'h0000155);
        freeze = 1'b1;
        tick();
        read_word(-1, w);
        check("test pattern", 32'(w), 32'h2AAAAAA);
        freeze = 1'b0;
        tick(); tick();
        check("pattern popped", 32'(token), 32'd0);
        en_tp = 1'b0;
`endif

        // Randomised traffic against the model
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            rst      = ($urandom_range(0, 799) == 0);
            hit_wr   = ($urandom_range(0, 2) != 0);
            hit_data = 26'($urandom);
            read     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) freeze = ~freeze;
            tick();
        end
        rst = 1'b0; hit_wr = 1'b0; read = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mono_data_tx.md
MONO_DATA_TX -- requirements
Module: mono_data_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning hit-FIFO depth in words (power of two, 4..256).
REQ-002 SHALL have port CLK  input  1  single clock for all logic (40 MHz BX domain).
REQ-003 SHALL have port RST  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port HIT_WR  input  1  writes HIT_DATA into the FIFO when high at a CLK edge.
REQ-005 SHALL have port HIT_DATA  input  26  hit word: col[25:20], row[19:12], TE[11:6], LE[5:0].
REQ-006 SHALL have port HIT_FULL  output  1  FIFO full.
REQ-007 SHALL have port READ  input  1  readout strobe from the DAQ receiver.
REQ-008 SHALL have port FREEZE  input  1  freeze request from the DAQ receiver.
REQ-009 SHALL have port TOKEN  output  1  hits pending for readout.
REQ-010 SHALL have port DATA  output  1  serial hit data, MSB first.
REQ-011 SHALL have port BUSY  output  1  high while in the LOAD or SHIFT state.
REQ-012 SHALL have port LOST_CNT  output  8  count of hits dropped on a full FIFO, saturating.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, LOAD, SHIFT.
REQ-014 SHALL detect a READ rising edge as READ=1 with the previous-cycle READ=0.
REQ-015 SHALL leave IDLE for LOAD only on a READ edge while FREEZE=1, state IDLE and SNAP_CNT>0.
REQ-016 SHALL ignore READ edges outside that condition, with no state change and no FIFO pop.
REQ-017 SHALL, in LOAD, pop one FIFO word into a 26-bit shift register, decrement SNAP_CNT and go to SHIFT.
REQ-018 SHALL, for a READ edge at cycle n, drive DATA=bit 25 at cycle n+2 through bit 0 at cycle n+27, then return to IDLE.
REQ-019 SHALL hold DATA=0 whenever the state is not SHIFT.
REQ-020 SHALL register TOKEN as FIFO non-empty while FREEZE=0.
REQ-021 SHALL, on a FREEZE rising edge, load SNAP_CNT with the current FIFO count.
REQ-022 SHALL, while FREEZE=1, register TOKEN as (SNAP_CNT≠0 or state≠IDLE); hits written during FREEZE SHALL NOT raise TOKEN.
REQ-023 SHALL, on a FREEZE falling edge, clear SNAP_CNT and let any word in SHIFT complete.
REQ-024 SHALL drop a write to a full FIFO and increment LOST_CNT, saturating at 255.
REQ-025 SHALL leave the FIFO count unchanged on a simultaneous write and pop, including when the FIFO is full.
REQ-026 SHALL use modulo-DEPTH FIFO pointers, with a count of width clog2(DEPTH)+1.

Reset
REQ-027 SHALL, when RST=1, set state=IDLE, empty the FIFO, and zero SNAP_CNT, LOST_CNT, TOKEN, DATA, BUSY and the READ/FREEZE edge registers.
REQ-028 SHALL, on RST asserted mid-SHIFT, drive DATA=0 the next cycle and discard the partial word.
REQ-029 SHALL deassert HIT_FULL while in reset.

Configuration
REQ-030 SHALL, with macro MONO_TX_TEST_PATTERN_EN defined, add input EN_TEST_PATTERN (1 bit).
REQ-031 SHALL, with that macro defined and EN_TEST_PATTERN=1, load TEST_PATTERN (26'h2AAAAAA) in LOAD instead of the FIFO word, while still popping and decrementing as normal.
REQ-032 SHALL, without that macro, have no EN_TEST_PATTERN port and always shift FIFO data.

Structure
REQ-033 SHALL place WORD_W=26, the field LSB/width constants, the FSM state typedef and TEST_PATTERN in the shared package mono_tx_pkg.
REQ-034 SHALL implement the FIFO as the sub-module mono_tx_fifo: synchronous, first-word-fall-through, with a count output.

Verification
REQ-035 SHALL verify: write 26'h3C0F0A5; FREEZE=1; READ pulse at cycle n -> DATA serialises 11_1100_0000_1111_0000_1010_0101 over n+2..n+27; TOKEN=0 at n+28.
REQ-036 SHALL verify: 3 hits queued; FREEZE=1; write 2 more; 3 READ pulses -> 3 words out, TOKEN=0; FREEZE=0 -> TOKEN=1 one cycle later.
REQ-037 SHALL verify: DEPTH=16; 20 writes with no reads -> HIT_FULL=1, LOST_CNT=4; 300 further writes -> LOST_CNT=255.
REQ-038 SHALL verify: READ edge during SHIFT, or with FREEZE=0 -> ignored; FIFO count unchanged; DATA stream uncorrupted.
REQ-039 SHALL verify: RST at bit 10 of a shift -> DATA=0 next cycle, TOKEN=0, FIFO empty, LOST_CNT=0.
REQ-040 SHALL verify, with MONO_TX_TEST_PATTERN_EN defined and EN_TEST_PATTERN=1: 1 hit queued; READ -> DATA serialises 26'h2AAAAAA and FIFO count decrements to 0.
